// File: rtl/ram_arbiter_if.sv
// CPU / DMA / SRAM signal bundle for the mapper RAM arbiter.
// No storage: pure wiring between requesters, arbiter and SRAM pins.
// slave = arbiter side, master = requester/SRAM model side.
interface ram_arbiter_if;
  // Z80 side
  logic        cpu_req;
  logic        cpu_we;
  logic [4:0]  cpu_bank;
  logic [13:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_wait_n;
  // loader / DMA side
  logic        dma_req;
  logic        dma_we;
  logic [18:0] dma_addr;
  logic [7:0]  dma_wdata;
  logic        dma_ack;
  logic [7:0]  dma_rdata;
  // SRAM pins
  logic [18:0] ram_a;
  logic        ram_ce_n;
  logic        ram_oe_n;
  logic        ram_we_n;
  logic [7:0]  ram_dq_o;
  logic        ram_dq_oe;
  logic [7:0]  ram_dq_i;

  modport slave (
    input  cpu_req, cpu_we, cpu_bank, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_wait_n,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_ack, dma_rdata,
    output ram_a, ram_ce_n, ram_oe_n, ram_we_n, ram_dq_o, ram_dq_oe,
    input  ram_dq_i
  );

  modport master (
    output cpu_req, cpu_we, cpu_bank, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_wait_n,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_ack, dma_rdata,
    input  ram_a, ram_ce_n, ram_oe_n, ram_we_n, ram_dq_o, ram_dq_oe,
    output ram_dq_i
  );
endinterface

// File: rtl/ram_arbiter.sv
// Shares one asynchronous SRAM between the Z80 (via mapper) and a loader DMA port.
// Latency: 2-flop sync + 1 grant cycle + ACC_CYC strobe cycles + 1 recover cycle.
// Backpressure: Z80 held with WAIT until its data is valid; DMA held until its ack pulse.
module ram_arbiter #(
  parameter int unsigned ACC_CYC    = 2,
  parameter int unsigned STARVE_LIM = 3
) (
  input logic          CLK,
  input logic          RSTb,
  ram_arbiter_if.slave bus
);

  localparam logic [2:0] ACC_LAST   = 3'(ACC_CYC - 1);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIM);

  typedef enum logic [2:0] {
    IDLE,
    CPU_ACC,
    DMA_ACC,
    RECOVER,
    CPU_HOLD
  } state_t;

  state_t      state;
  state_t      state_nxt;

  // cpu_req comes straight from Z80 bus decode, so it is synchronized first
  logic        creq_meta;
  logic        creq_s;

  // access bookkeeping, latched at grant
  logic [2:0]  acc_cnt;
  logic        acc_dma;
  logic        acc_we;
  logic [18:0] ram_a_r;
  logic [7:0]  dq_o_r;

  logic [3:0]  starve_cnt;
  logic        cpu_done;
  logic [7:0]  cpu_rdata_r;
  logic [7:0]  dma_rdata_r;

  // combinational decode
  logic        grant_cpu;
  logic        grant_dma;
  logic        acc_last;
  logic        ce_n;
  logic        oe_n;
  logic        we_n;
  logic        dq_oe;
  logic        ack;

  // Next-state, grant decisions and SRAM strobes from the current state.
  always_comb begin
    state_nxt = state;
    grant_cpu = 1'b0;
    grant_dma = 1'b0;
    acc_last  = 1'b0;
    ce_n      = 1'b1;
    oe_n      = 1'b1;
    we_n      = 1'b1;
    dq_oe     = 1'b0;
    ack       = 1'b0;
    case (state)
      IDLE: begin
        // CPU wins unless DMA has already been passed over STARVE_LIM times
        if (creq_s && (!bus.dma_req || (starve_cnt < STARVE_MAX))) begin
          grant_cpu = 1'b1;
          state_nxt = CPU_ACC;
        end else if (bus.dma_req) begin
          grant_dma = 1'b1;
          state_nxt = DMA_ACC;
        end
      end
      CPU_ACC, DMA_ACC: begin
        ce_n  = 1'b0;
        oe_n  = acc_we;
        we_n  = !acc_we;
        dq_oe = acc_we;
        if (acc_cnt == ACC_LAST) begin
          acc_last  = 1'b1;
          state_nxt = RECOVER;
        end
      end
      RECOVER: begin
        // bus turnaround cycle; DMA completion is signalled here
        ack       = acc_dma;
        state_nxt = acc_dma ? IDLE : CPU_HOLD;
      end
      CPU_HOLD: begin
        // wait for the Z80 to end its bus cycle so it gets exactly one access
        if (!creq_s) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Two-flop synchronizer for the asynchronous CPU request.
  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      creq_meta <= 1'b0;
      creq_s    <= 1'b0;
    end else begin
      creq_meta <= bus.cpu_req;
      creq_s    <= creq_meta;
    end
  end

  // State register; reset aborts any access in flight.
  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Strobe-width counter: restarts on each grant, advances while strobing.
  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      acc_cnt <= 3'd0;
    end else if (grant_cpu || grant_dma) begin
      acc_cnt <= 3'd0;
    end else if ((state == CPU_ACC) || (state == DMA_ACC)) begin
      acc_cnt <= acc_cnt + 3'd1;
    end
  end

  // Latch owner, direction, address and write data at grant; held through RECOVER.
  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      acc_dma <= 1'b0;
      acc_we  <= 1'b0;
      ram_a_r <= 19'd0;
      dq_o_r  <= 8'd0;
    end else if (grant_cpu) begin
      acc_dma <= 1'b0;
      acc_we  <= bus.cpu_we;
      ram_a_r <= {bus.cpu_bank, bus.cpu_addr};
      dq_o_r  <= bus.cpu_wdata;
    end else if (grant_dma) begin
      acc_dma <= 1'b1;
      acc_we  <= bus.dma_we;
      ram_a_r <= bus.dma_addr;
      dq_o_r  <= bus.dma_wdata;
    end
  end

  // Count CPU grants that overtook a waiting DMA; any DMA grant clears it.
  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      starve_cnt <= 4'd0;
    end else if (grant_dma) begin
      starve_cnt <= 4'd0;
    end else if (grant_cpu && bus.dma_req && (starve_cnt != STARVE_MAX)) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // Capture SRAM read data on the last strobe cycle into the owner's register.
  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      cpu_rdata_r <= 8'd0;
      dma_rdata_r <= 8'd0;
    end else if (acc_last && !acc_we) begin
      if (acc_dma) begin
        dma_rdata_r <= bus.ram_dq_i;
      end else begin
        cpu_rdata_r <= bus.ram_dq_i;
      end
    end
  end

  // cpu_done releases WAIT from the end of CPU RECOVER until the Z80 drops its request.
  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      cpu_done <= 1'b0;
    end else if ((state == RECOVER) && !acc_dma) begin
      cpu_done <= 1'b1;
    end else if ((state == CPU_HOLD) && !creq_s) begin
      cpu_done <= 1'b0;
    end
  end

  // WAIT uses the raw request so the Z80 is stalled from the very first T-state.
  assign bus.cpu_wait_n = !(bus.cpu_req && !cpu_done);
  assign bus.cpu_rdata  = cpu_rdata_r;
  assign bus.dma_ack    = ack;
  assign bus.dma_rdata  = dma_rdata_r;
  assign bus.ram_a      = ram_a_r;
  assign bus.ram_ce_n   = ce_n;
  assign bus.ram_oe_n   = oe_n;
  assign bus.ram_we_n   = we_n;
  assign bus.ram_dq_o   = dq_o_r;
  assign bus.ram_dq_oe  = dq_oe;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios with a cycle-scheduled reference model.
// The model predicts every cycle's SRAM strobes, ack and WAIT from grant times.
// Inputs are driven at negedge (or just after posedge); outputs compared 1 ns after posedge.
module tb_ram_arbiter;
  localparam int ACC = 2;
  localparam int LIM = 3;

  logic CLK  = 1'b0;
  logic RSTb = 1'b0;
  always #5 CLK = ~CLK;

  ram_arbiter_if bus();

  ram_arbiter #(.ACC_CYC(ACC), .STARVE_LIM(LIM)) dut (
    .CLK (CLK),
    .RSTb(RSTb),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (schedule of grants) ----------------
  int          cyc = 0;
  int          free_at = 0;
  int          hold_from = 0;
  int          acc_start = 0;
  int          cap_edge = 0;
  int          m_starve = 0;
  bit          m_holding = 0, m_done = 0, acc_valid = 0, acc_dma = 0, acc_we = 0;
  bit          cap_pending = 0, cap_dma = 0, m_s1 = 0, m_creq = 0, creq_old = 0;
  logic [18:0] m_a = '0;
  logic [7:0]  m_wd = '0, m_crd = '0, m_drd = '0;

  always @(posedge CLK) begin
    cyc++;
    if (!RSTb) begin
      m_s1 = 0; m_creq = 0; m_holding = 0; m_done = 0; m_starve = 0;
      acc_valid = 0; cap_pending = 0; free_at = cyc;
      m_a = '0; m_wd = '0; m_crd = '0; m_drd = '0;
    end else begin
      creq_old = m_creq;
      if (cap_pending && cyc == cap_edge) begin
        if (cap_dma) m_drd = bus.ram_dq_i;
        else         m_crd = bus.ram_dq_i;
        cap_pending = 0;
      end
      if (m_holding) begin
        if (cyc == hold_from) m_done = 1;
        else if (cyc - 1 >= hold_from && !creq_old) begin
          m_holding = 0; m_done = 0; free_at = cyc;
        end
      end else if (cyc - 1 >= free_at) begin
        if (creq_old && (!bus.dma_req || m_starve < LIM)) begin
          if (bus.dma_req && m_starve < LIM) m_starve++;
          acc_valid = 1; acc_start = cyc; acc_dma = 0; acc_we = bus.cpu_we;
          m_a = {bus.cpu_bank, bus.cpu_addr}; m_wd = bus.cpu_wdata;
          if (!bus.cpu_we) begin cap_pending = 1; cap_edge = cyc + ACC; cap_dma = 0; end
          m_holding = 1; hold_from = cyc + ACC + 1;
        end else if (bus.dma_req) begin
          m_starve = 0;
          acc_valid = 1; acc_start = cyc; acc_dma = 1; acc_we = bus.dma_we;
          m_a = bus.dma_addr; m_wd = bus.dma_wdata;
          if (!bus.dma_we) begin cap_pending = 1; cap_edge = cyc + ACC; cap_dma = 1; end
          free_at = cyc + ACC + 1;
        end
      end
      m_creq = m_s1;
      m_s1   = bus.cpu_req;
    end
  end

  // ---------------- per-cycle compare + access log ----------------
  bit          e_acc, e_rec;
  logic        prev_ce = 1'b1;
  int          ack_total = 0;
  logic [18:0] acc_log[$];

  always @(posedge CLK) begin
    #1;
    e_acc = acc_valid && cyc >= acc_start && cyc < acc_start + ACC;
    e_rec = acc_valid && cyc == acc_start + ACC;
    chk("ram_ce_n",   32'(bus.ram_ce_n),   32'(!e_acc));
    chk("ram_oe_n",   32'(bus.ram_oe_n),   32'(!(e_acc && !acc_we)));
    chk("ram_we_n",   32'(bus.ram_we_n),   32'(!(e_acc && acc_we)));
    chk("ram_dq_oe",  32'(bus.ram_dq_oe),  32'(e_acc && acc_we));
    chk("dma_ack",    32'(bus.dma_ack),    32'(e_rec && acc_dma));
    chk("ram_a",      32'(bus.ram_a),      32'(m_a));
    chk("cpu_rdata",  32'(bus.cpu_rdata),  32'(m_crd));
    chk("dma_rdata",  32'(bus.dma_rdata),  32'(m_drd));
    chk("cpu_wait_n", 32'(bus.cpu_wait_n), 32'(!(bus.cpu_req && !m_done)));
    chk("starve_cnt", 32'(dut.starve_cnt), 32'(m_starve));
    if (e_acc && acc_we) chk("ram_dq_o", 32'(bus.ram_dq_o), 32'(m_wd));
    if (bus.ram_ce_n == 1'b0 && prev_ce == 1'b1) acc_log.push_back(bus.ram_a);
    prev_ce = bus.ram_ce_n;
    if (bus.dma_ack) ack_total++;
  end

  // ---------------- stimulus helpers ----------------
  // Waits for WAIT to assert for this request and then release.
  task automatic wait_cpu_done(input string nm);
    int n = 0;
    @(negedge CLK);
    while (bus.cpu_wait_n === 1'b1 && n < 10) begin @(negedge CLK); n++; end
    n = 0;
    while (bus.cpu_wait_n !== 1'b1 && n < 60) begin @(negedge CLK); n++; end
    checks++;
    if (n >= 60) begin
      errors++;
      $display("FAIL %s: cpu_wait_n still low after 60 cycles, required high", nm);
    end
  endtask

  task automatic dma_txn(input logic we, input logic [18:0] a, input logic [7:0] wd,
                         input string nm);
    int n = 0;
    bus.dma_we = we; bus.dma_addr = a; bus.dma_wdata = wd; bus.dma_req = 1'b1;
    do begin @(negedge CLK); n++; end while (bus.dma_ack !== 1'b1 && n < 80);
    checks++;
    if (n >= 80) begin
      errors++;
      $display("FAIL %s: dma_ack still 0 after 80 cycles, required 1", nm);
    end
    bus.dma_req = 1'b0;
  endtask

  task automatic cpu_burst(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      wait_cpu_done("starve_cpu_done");
      bus.cpu_req = 1'b0;
      @(negedge CLK);
      if (i < cnt - 1) bus.cpu_req = 1'b1;
    end
  endtask

  task automatic set_cpu(input logic we, input logic [4:0] bank, input logic [13:0] a);
    bus.cpu_we = we; bus.cpu_bank = bank; bus.cpu_addr = a;
  endtask

  // ---------------- scenarios ----------------
  int we_low, acks, ack_snap, n;

  initial begin
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_bank = '0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dma_req = 0; bus.dma_we = 0; bus.dma_addr = '0; bus.dma_wdata = '0; bus.ram_dq_i = '0;

    // reset state
    repeat (3) @(negedge CLK);
    chk("rst_ce_n", 32'(bus.ram_ce_n), 32'd1);
    chk("rst_oe_n", 32'(bus.ram_oe_n), 32'd1);
    chk("rst_we_n", 32'(bus.ram_we_n), 32'd1);
    chk("rst_dq_oe", 32'(bus.ram_dq_oe), 32'd0);
    chk("rst_ack", 32'(bus.dma_ack), 32'd0);
    chk("rst_ram_a", 32'(bus.ram_a), 32'd0);
    RSTb = 1'b1;
    repeat (2) @(negedge CLK);

    // CPU read: sampled edge is 1, access cycles 3-4, recover 5, WAIT release 6
    bus.ram_dq_i = 8'hA5;
    set_cpu(1'b0, 5'h03, 14'h0123);
    bus.cpu_req = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge CLK); #1;
      chk("rd_wait_n", 32'(bus.cpu_wait_n), (k == 6) ? 32'd1 : 32'd0);
      if (k == 3) chk("rd_ram_a", 32'(bus.ram_a), 32'h0C123);
      if (k == 3 || k == 4) chk("rd_oe_low", 32'(bus.ram_oe_n), 32'd0);
      if (k == 5) chk("rd_oe_high", 32'(bus.ram_oe_n), 32'd1);
      if (k == 6) chk("rd_cpu_rdata", 32'(bus.cpu_rdata), 32'hA5);
    end
    @(negedge CLK);
    bus.cpu_req = 1'b0;
    repeat (4) @(negedge CLK);

    // DMA write, with dma_we flipped after grant (must be ignored)
    we_low = 0; acks = 0;
    bus.dma_we = 1'b1; bus.dma_addr = 19'h7FFFF; bus.dma_wdata = 8'h3C; bus.dma_req = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge CLK); #1;
      if (bus.ram_we_n == 1'b0) we_low++;
      if (bus.dma_ack) acks++;
      if (k == 1) begin
        chk("wr_dq_o", 32'(bus.ram_dq_o), 32'h3C);
        chk("wr_ram_a", 32'(bus.ram_a), 32'h7FFFF);
        bus.dma_we = 1'b0;
      end
      if (k == 3) begin
        chk("wr_ack_cycle", 32'(bus.dma_ack), 32'd1);
        bus.dma_req = 1'b0;
      end
    end
    chk("wr_we_cycles", 32'(we_low), 32'd2);
    chk("wr_ack_count", 32'(acks), 32'd1);
    @(negedge CLK);

    // simultaneous requests: CPU first, DMA after CPU_HOLD
    acc_log.delete();
    bus.ram_dq_i = 8'h5A;
    set_cpu(1'b0, 5'h01, 14'h0010);
    bus.cpu_req = 1'b1;
    repeat (2) @(negedge CLK);
    fork
      dma_txn(1'b0, 19'h12345, 8'h00, "sim_dma");
      begin wait_cpu_done("sim_cpu"); bus.cpu_req = 1'b0; end
    join
    repeat (4) @(negedge CLK);
    chk("sim_log_size", 32'(acc_log.size()), 32'd2);
    chk("sim_first_cpu", 32'(acc_log[0]), 32'h04010);
    chk("sim_then_dma", 32'(acc_log[1]), 32'h12345);
    chk("sim_dma_rdata", 32'(bus.dma_rdata), 32'h5A);

    // starvation: three CPU grants, then DMA is forced ahead of the 4th
    acc_log.delete();
    set_cpu(1'b0, 5'h1F, 14'h3FFF);
    bus.cpu_req = 1'b1;
    repeat (2) @(negedge CLK);
    fork
      dma_txn(1'b0, 19'h00ABC, 8'h00, "starve_dma");
      cpu_burst(4);
    join
    repeat (3) @(negedge CLK);
    chk("starve_log_size", 32'(acc_log.size()), 32'd5);
    chk("starve_cpu0", 32'(acc_log[0]), 32'h7FFFF);
    chk("starve_cpu2", 32'(acc_log[2]), 32'h7FFFF);
    chk("starve_dma3", 32'(acc_log[3]), 32'h00ABC);
    chk("starve_cpu4", 32'(acc_log[4]), 32'h7FFFF);
    chk("starve_cnt_cleared", 32'(dut.starve_cnt), 32'd0);

    // CPU arrives on the first DMA_ACC cycle
    acc_log.delete();
    bus.ram_dq_i = 8'hC3;
    set_cpu(1'b0, 5'h02, 14'h0200);
    fork
      dma_txn(1'b1, 19'h00100, 8'h77, "dur_dma");
      begin
        @(negedge CLK);
        bus.cpu_req = 1'b1;
        n = 0;
        do begin
          @(negedge CLK); n++;
          chk("dur_wait_low", 32'(bus.cpu_wait_n), 32'd0);
        end while (bus.dma_ack !== 1'b1 && n < 20);
        wait_cpu_done("dur_cpu");
        bus.cpu_req = 1'b0;
      end
    join
    repeat (4) @(negedge CLK);
    chk("dur_log_size", 32'(acc_log.size()), 32'd2);
    chk("dur_dma_first", 32'(acc_log[0]), 32'h00100);
    chk("dur_cpu_second", 32'(acc_log[1]), 32'h08200);
    chk("dur_cpu_rdata", 32'(bus.cpu_rdata), 32'hC3);

    // dma_req withdrawn before it is ever granted: no access, no ack
    acc_log.delete();
    ack_snap = ack_total;
    set_cpu(1'b0, 5'h04, 14'h0004);
    bus.cpu_req = 1'b1;
    repeat (4) @(negedge CLK);
    bus.dma_addr = 19'h55555; bus.dma_we = 1'b0; bus.dma_req = 1'b1;
    @(negedge CLK);
    bus.dma_req = 1'b0;
    wait_cpu_done("drop_cpu");
    bus.cpu_req = 1'b0;
    repeat (6) @(negedge CLK);
    chk("drop_log_size", 32'(acc_log.size()), 32'd1);
    chk("drop_cpu_only", 32'(acc_log[0]), 32'h10004);
    chk("drop_no_ack", 32'(ack_total - ack_snap), 32'd0);

    // reset on the 2nd CPU_ACC cycle
    ack_snap = ack_total;
    set_cpu(1'b1, 5'h06, 14'h0666);
    bus.cpu_wdata = 8'h99;
    bus.cpu_req = 1'b1;
    n = 0;
    do begin @(negedge CLK); n++; end while (bus.ram_ce_n !== 1'b0 && n < 20);
    chk("rst_mid_reached_acc", 32'(bus.ram_ce_n), 32'd0);
    @(negedge CLK);
    RSTb = 1'b0;
    @(posedge CLK); #1;
    chk("rst_mid_ce_n", 32'(bus.ram_ce_n), 32'd1);
    chk("rst_mid_we_n", 32'(bus.ram_we_n), 32'd1);
    chk("rst_mid_oe_n", 32'(bus.ram_oe_n), 32'd1);
    chk("rst_mid_dq_oe", 32'(bus.ram_dq_oe), 32'd0);
    chk("rst_mid_wait_low", 32'(bus.cpu_wait_n), 32'd0);
    @(negedge CLK);
    bus.cpu_req = 1'b0;
    @(posedge CLK); #1;
    chk("rst_mid_wait_high", 32'(bus.cpu_wait_n), 32'd1);
    @(negedge CLK);
    RSTb = 1'b1;
    repeat (5) @(negedge CLK);
    chk("rst_mid_no_ack", 32'(ack_total - ack_snap), 32'd0);

    repeat (2) @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time (checks %0d)", checks);
    $fatal(1, "watchdog expired");
  end
endmodule
